instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs decoded instruction fields back into 32-bit instruction words. This is the exact inverse of `decoder_control`'s field split.
- Streams the packed words into instruction memory. Used by the program loader and by self-checking benches, which feed `decoder_control` with encoded words.
- Field input uses a valid/ready handshake. Words are buffered in a small FIFO and written to memory sequentially from a base address.

Parameters:
- ADDR_W, 10: instruction memory address width.
- FIFO_DEPTH, 4: word buffer depth; power of two, at least 2.
- COUNT_W, 8: width of the instruction count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads base_addr and count; ignored unless in IDLE.
- base_addr  in  ADDR_W  first memory address.
- count  in  COUNT_W  number of field beats to accept.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat.
- cond  in  4  condition field.
- op  in  2  opcode class: 00 data, 01 memory, 10 branch, 11 illegal.
- imm_sel  in  1  immediate operand select (op 00/01).
- cmd  in  4  ALU/memory command.
- set_flag  in  1  flag update enable.
- src_addr  in  4  source register.
- dest_reg  in  4  destination register.
- imm12  in  12  12-bit immediate (op 00/01).
- link  in  1  register jump/link (op 10).
- imm24  in  24  branch immediate (op 10).
- mem_wr_en  out  1  memory write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when the run completes.
- err  out  1  sticky illegal-op flag; cleared on an accepted start.

Behaviour:
- Word layout, bit fields:
  - All ops: [31:28] cond, [27:26] op.
  - op 00/01: [25] imm_sel, [24:21] cmd, [20] set_flag, [19:16] src_addr, [15:12] dest_reg, [11:0] imm12.
  - op 10: [25] 0, [24] link, [23:0] imm24.
- Packing is combinational into the FIFO write port.
- Reset values: in_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. FIFO is empty, state is IDLE.
- FSM states are IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start with count>0. Loads the address pointer with base_addr and clears err and the accepted counter.
  - IDLE -> DONE on start with count==0.
  - RUN -> FLUSH once the accepted count reaches count.
  - FLUSH -> DONE when the FIFO is empty and no write is outstanding.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Handshake rules:
  - in_ready = (state==RUN) && !fifo_full && (accepted<count).
  - A beat is accepted when in_valid && in_ready.
  - No combinational path from in_valid to in_ready.
- Illegal op (op==11):
  - The beat is accepted and counted toward count.
  - The word is not pushed to the FIFO.
  - err is set and stays set until the next start.
- Write side:
  - mem_wr_en, mem_addr and mem_wdata are registered from the FIFO head.
  - A write completes on mem_wr_en && mem_ready.
  - While mem_ready=0, mem_wr_en, mem_addr and mem_wdata hold stable.
  - The address increments by 1 after each completed write only and wraps modulo 2^ADDR_W.
- Latency: a beat accepted into an empty FIFO drives mem_wr_en on the next cycle. With mem_ready held high, throughput is 1 word per cycle.
- Simultaneous push and pop in one cycle is allowed whenever the FIFO is not full. When full, in_ready=0 even if a pop occurs that cycle.
- start while busy is ignored, with no state change.
- Reset mid-operation returns all state to reset values immediately. Buffered words are discarded.

Optional Feature:
- Macro: INSTR_ENC_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], a running XOR of every word written (completed writes only).
  - checksum is cleared to 0 on accepted start and on reset, and holds its value after DONE.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `isa_pkg`:
  - op encodings OP_DATA=2'b00, OP_MEM=2'b01, OP_BRANCH=2'b10, OP_ILLEGAL=2'b11.
  - Bit-position constants for every field.
  - FSM state typedef.
  - Used by both `decoder_control` and this block.
- One sub-module: `sync_fifo` (WIDTH=32, DEPTH=FIFO_DEPTH) with full/empty flags.

Test Plan:
- Data word: start base=0x010 count=1, beat cond=E op=00 imm_sel=1 cmd=4 S=1 src=1 dest=2 imm12=0x005, mem_ready=1 -> write 0xE2912005 @0x010 on the cycle after acceptance; done the cycle after FLUSH ends; err=0.
- Branch word: count=1, beat cond=A op=10 link=1 imm24=0x00000F -> write 0xA900000F.
- Backpressure: count=6, in_valid stuck high, mem_ready=0 -> exactly 4 beats accepted, then in_ready=0. Raise mem_ready -> 6 writes at consecutive addresses, data held stable during stalls.
- Illegal op: count=3 with the middle beat op=11 -> 2 writes at base and base+1; err=1 until the next start.
- Wrap and edge cases:
  - ADDR_W=10, base=0x3FF, count=2 -> writes at 0x3FF then 0x000.
  - count=0 -> done pulse one cycle after start, no writes.
- Reset mid-run: assert rst_n=0 with 2 words buffered -> all outputs go to reset values, no further writes; with the macro defined, checksum=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions: op encodings, instruction field positions, FSM state type
// and the field-to-word packing function used by the encoder and decoder.
package isa_pkg;

  localparam logic [1:0] OP_DATA    = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BRANCH  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int unsigned COND_LSB     = 28;
  localparam int unsigned COND_W       = 4;
  localparam int unsigned OP_LSB       = 26;
  localparam int unsigned OP_W         = 2;
  localparam int unsigned IMM_SEL_BIT  = 25;
  localparam int unsigned CMD_LSB      = 21;
  localparam int unsigned CMD_W        = 4;
  localparam int unsigned SET_FLAG_BIT = 20;
  localparam int unsigned SRC_LSB      = 16;
  localparam int unsigned DEST_LSB     = 12;
  localparam int unsigned REG_W        = 4;
  localparam int unsigned IMM12_LSB    = 0;
  localparam int unsigned IMM12_W      = 12;
  localparam int unsigned LINK_BIT     = 24;
  localparam int unsigned IMM24_LSB    = 0;
  localparam int unsigned IMM24_W      = 24;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm_sel;
    logic [3:0]  cmd;
    logic        set_flag;
    logic [3:0]  src_addr;
    logic [3:0]  dest_reg;
    logic [11:0] imm12;
    logic        link;
    logic [23:0] imm24;
  } fields_t;

  // Branch words use the link/imm24 layout; every other op uses the data/memory layout.
  function automatic logic [31:0] pack_word(input fields_t f);
    logic [31:0] w;
    w = '0;
    w[COND_LSB +: COND_W] = f.cond;
    w[OP_LSB +: OP_W]     = f.op;
    if (f.op == OP_BRANCH) begin
      w[LINK_BIT]              = f.link;
      w[IMM24_LSB +: IMM24_W]  = f.imm24;
    end else begin
      w[IMM_SEL_BIT]           = f.imm_sel;
      w[CMD_LSB +: CMD_W]      = f.cmd;
      w[SET_FLAG_BIT]          = f.set_flag;
      w[SRC_LSB +: REG_W]      = f.src_addr;
      w[DEST_LSB +: REG_W]     = f.dest_reg;
      w[IMM12_LSB +: IMM12_W]  = f.imm12;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head and head+1 peek ports, occupancy level and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic [WIDTH-1:0]         rd_next_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c    = (level == LW'(DEPTH));
  assign empty_c   = (level == '0);
  assign push_ok   = push && !full_c;
  assign pop_ok    = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr];
  assign rd_next_c = mem[AW'(rd_ptr + 1'b1)];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop_ok)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({push_ok, pop_ok})
        2'b10:   level <= LW'(level + 1'b1);
        2'b01:   level <= LW'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words and streams them to instruction memory.
// Optional INSTR_ENC_CHECKSUM_EN adds a running XOR of every completed write.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         cond,
  input  logic [1:0]         op,
  input  logic               imm_sel,
  input  logic [3:0]         cmd,
  input  logic               set_flag,
  input  logic [3:0]         src_addr,
  input  logic [3:0]         dest_reg,
  input  logic [11:0]        imm12,
  input  logic               link,
  input  logic [23:0]        imm24,
  output logic               mem_wr_en,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] acc_q;
  fields_t            fields_c;
  logic [31:0]        word_c;
  logic               start_ok_c;
  logic               beat_c;
  logic               push_c;
  logic               pop_c;
  logic [31:0]        fifo_head_c;
  logic [31:0]        fifo_next_c;
  logic [LVL_W-1:0]   fifo_level;
  logic [LVL_W-1:0]   lvl_next_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;

  assign fields_c = '{cond: cond, op: op, imm_sel: imm_sel, cmd: cmd, set_flag: set_flag,
                      src_addr: src_addr, dest_reg: dest_reg, imm12: imm12,
                      link: link, imm24: imm24};
  assign word_c     = pack_word(fields_c);
  assign start_ok_c = start && (state_q == ST_IDLE);
  assign in_ready   = (state_q == ST_RUN) && !fifo_full_c && (acc_q < count_q);
  assign beat_c     = in_valid && in_ready;
  assign push_c     = beat_c && (op != OP_ILLEGAL);
  // The head entry stays in the FIFO until memory takes it, so depth bounds accepted beats.
  assign pop_c      = mem_wr_en && mem_ready;
  assign lvl_next_c = LVL_W'(fifo_level + LVL_W'(push_c) - LVL_W'(pop_c));

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (word_c),
    .rd_data_c (fifo_head_c),
    .rd_next_c (fifo_next_c),
    .level     (fifo_level),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (acc_q == count_q) state_d = ST_FLUSH;
      ST_FLUSH: if (fifo_empty_c && !mem_wr_en) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers and the memory write port, which tracks the post-update FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      acc_q     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
      if (start_ok_c) begin
        count_q  <= count;
        acc_q    <= '0;
        err      <= 1'b0;
        mem_addr <= base_addr;
`ifdef INSTR_ENC_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        if (beat_c) acc_q <= COUNT_W'(acc_q + 1'b1);
        if (beat_c && (op == OP_ILLEGAL)) err <= 1'b1;
        if (pop_c) begin
          mem_addr <= ADDR_W'(mem_addr + 1'b1);
`ifdef INSTR_ENC_CHECKSUM_EN
          checksum <= checksum ^ mem_wdata;
`endif
        end
      end
      mem_wr_en <= (lvl_next_c != '0);
      if (lvl_next_c != '0) begin
        if (pop_c)             mem_wdata <= (fifo_level >= LVL_W'(2)) ? fifo_next_c : word_c;
        else if (fifo_empty_c) mem_wdata <= word_c;
        else                   mem_wdata <= fifo_head_c;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; honours INSTR_ENC_CHECKSUM_EN.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = '0;
  logic [1:0]  op = '0;
  logic        imm_sel = 1'b0;
  logic [3:0]  cmd = '0;
  logic        set_flag = 1'b0;
  logic [3:0]  src_addr = '0;
  logic [3:0]  dest_reg = '0;
  logic [11:0] imm12 = '0;
  logic        link = 1'b0;
  logic [23:0] imm24 = '0;
  logic        mem_wr_en;
  logic        mem_ready = 1'b1;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .cond(cond), .op(op), .imm_sel(imm_sel),
    .cmd(cmd), .set_flag(set_flag), .src_addr(src_addr), .dest_reg(dest_reg),
    .imm12(imm12), .link(link), .imm24(imm24), .mem_wr_en(mem_wr_en),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_wr_en && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [3:0] c, input logic [1:0] o, input logic is,
                          input logic [3:0] cm, input logic s, input logic [3:0] sr,
                          input logic [3:0] d, input logic [11:0] im);
    cond = c; op = o; imm_sel = is; cmd = cm; set_flag = s;
    src_addr = sr; dest_reg = d; imm12 = im; link = 1'b0; imm24 = '0;
  endtask

  task automatic set_branch(input logic [3:0] c, input logic l, input logic [23:0] im);
    cond = c; op = 2'b10; link = l; imm24 = im;
    imm_sel = 1'b0; cmd = '0; set_flag = 1'b0; src_addr = '0; dest_reg = '0; imm12 = '0;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [7:0] c);
    base_addr = b; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({in_ready, mem_wr_en, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000", {in_ready, mem_wr_en, busy, done, err});
    end
    n_checks++;
    if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%h data=%h want 0/0", mem_addr, mem_wdata);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    n_checks++;
    if (checksum !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_checksum got %h want 0", checksum);
    end
`endif
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got busy=%b in_ready=%b want 0/0", busy, in_ready);
    end
  endtask

  task automatic test_data_word();
    int idx = wr_addr_q.size();
    set_data(4'hE, 2'b00, 1'b1, 4'h4, 1'b1, 4'h1, 4'h2, 12'h005);
    do_start(10'h010, 8'd1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL data_run_entry got busy=%b in_ready=%b want 1/1", busy, in_ready);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'hE2912005) begin
      n_fail++;
      $display("FAIL data_write got en=%b addr=%h data=%h want 1/010/e2912005",
               mem_wr_en, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if (mem_wr_en !== 1'b0 || done !== 1'b0 || wr_addr_q.size() != idx + 1) begin
      n_fail++;
      $display("FAIL data_flush got en=%b done=%b writes=%0d want 0/0/1",
               mem_wr_en, done, wr_addr_q.size() - idx);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL data_done got done=%b err=%b want 1/0", done, err);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL data_idle got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_branch_word();
    int idx = wr_addr_q.size();
    bit ok;
    bit found;
    set_branch(4'hA, 1'b1, 24'h00000F);
    do_start(10'h020, 8'd1);
    send_beat(ok);
    wait_done(found);
    n_checks++;
    if (!ok || !found || wr_addr_q.size() != idx + 1) begin
      n_fail++;
      $display("FAIL branch_flow got ok=%b done=%b writes=%0d want 1/1/1",
               ok, found, wr_addr_q.size() - idx);
    end else begin
      n_checks++;
      if (wr_addr_q[idx] !== 10'h020 || wr_data_q[idx] !== 32'hA900000F) begin
        n_fail++;
        $display("FAIL branch_word got addr=%h data=%h want 020/a900000f",
                 wr_addr_q[idx], wr_data_q[idx]);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = wr_addr_q.size();
    int n_acc = 0;
    bit stable = 1'b1;
    bit found = 1'b0;
    bit acc_now;
    logic [31:0] exp_sum = '0;
    set_data(4'h0, 2'b01, 1'b0, 4'h2, 1'b0, 4'h3, 4'h4, 12'h000);
    mem_ready = 1'b0;
    do_start(10'h100, 8'd6);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc_now = in_ready;
      tick();
      if (acc_now) begin
        n_acc++;
        imm12 = 12'(n_acc);
      end
      if (mem_wr_en !== 1'b1 || mem_addr !== 10'h100 || mem_wdata !== 32'h04434000) stable = 1'b0;
    end
    n_checks++;
    if (n_acc != 4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept got accepted=%0d in_ready=%b want 4/0", n_acc, in_ready);
    end
    n_checks++;
    if (!stable || wr_addr_q.size() != idx) begin
      n_fail++;
      $display("FAIL bp_stall_hold got stable=%b writes=%0d want 1/0", stable, wr_addr_q.size() - idx);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      acc_now = in_ready;
      tick();
      if (acc_now) begin
        n_acc++;
        imm12 = 12'(n_acc);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!found || n_acc != 6 || wr_addr_q.size() != idx + 6) begin
      n_fail++;
      $display("FAIL bp_drain got done=%b accepted=%0d writes=%0d want 1/6/6",
               found, n_acc, wr_addr_q.size() - idx);
    end
    for (int i = 0; i < 6; i++) begin
      exp_sum = exp_sum ^ (32'h04434000 + 32'(i));
      if (idx + i < wr_addr_q.size()) begin
        n_checks++;
        if (wr_addr_q[idx+i] !== 10'(10'h100 + i) || wr_data_q[idx+i] !== 32'h04434000 + 32'(i)) begin
          n_fail++;
          $display("FAIL bp_write%0d got addr=%h data=%h want %h/%h", i, wr_addr_q[idx+i],
                   wr_data_q[idx+i], 10'(10'h100 + i), 32'h04434000 + 32'(i));
        end
      end
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    tick();
    n_checks++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL bp_checksum got %h want %h", checksum, exp_sum);
    end
`endif
    tick();
  endtask

  task automatic test_illegal();
    int idx = wr_addr_q.size();
    bit ok0, ok1, ok2, found;
    do_start(10'h040, 8'd3);
    set_data(4'h1, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h001);
    send_beat(ok0);
    set_data(4'hF, 2'b11, 1'b1, 4'hF, 1'b1, 4'hF, 4'hF, 12'hFFF);
    send_beat(ok1);
    set_data(4'h1, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h003);
    send_beat(ok2);
    wait_done(found);
    n_checks++;
    if (!(ok0 && ok1 && ok2 && found) || wr_addr_q.size() != idx + 2) begin
      n_fail++;
      $display("FAIL illegal_flow got beats=%b%b%b done=%b writes=%0d want 111/1/2",
               ok0, ok1, ok2, found, wr_addr_q.size() - idx);
    end else begin
      n_checks++;
      if (wr_addr_q[idx] !== 10'h040 || wr_data_q[idx] !== 32'h10000001 ||
          wr_addr_q[idx+1] !== 10'h041 || wr_data_q[idx+1] !== 32'h10000003) begin
        n_fail++;
        $display("FAIL illegal_writes got %h:%h %h:%h want 040:10000001 041:10000003",
                 wr_addr_q[idx], wr_data_q[idx], wr_addr_q[idx+1], wr_data_q[idx+1]);
      end
    end
    tick();
    tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err_sticky got %b want 1", err);
    end
  endtask

  task automatic test_wrap();
    int idx = wr_addr_q.size();
    bit ok0, ok1, found;
    do_start(10'h3FF, 8'd2);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_err_clear got %b want 0", err);
    end
    set_data(4'h1, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h007);
    send_beat(ok0);
    set_data(4'h1, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h008);
    send_beat(ok1);
    wait_done(found);
    n_checks++;
    if (!(ok0 && ok1 && found) || wr_addr_q.size() != idx + 2) begin
      n_fail++;
      $display("FAIL wrap_flow got beats=%b%b done=%b writes=%0d want 11/1/2",
               ok0, ok1, found, wr_addr_q.size() - idx);
    end else begin
      n_checks++;
      if (wr_addr_q[idx] !== 10'h3FF || wr_data_q[idx] !== 32'h10000007 ||
          wr_addr_q[idx+1] !== 10'h000 || wr_data_q[idx+1] !== 32'h10000008) begin
        n_fail++;
        $display("FAIL wrap_writes got %h:%h %h:%h want 3ff:10000007 000:10000008",
                 wr_addr_q[idx], wr_data_q[idx], wr_addr_q[idx+1], wr_data_q[idx+1]);
      end
    end
  endtask

  task automatic test_count_zero();
    int idx = wr_addr_q.size();
    do_start(10'h055, 8'd0);
    n_checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got done=%b in_ready=%b want 1/0", done, in_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0 || wr_addr_q.size() != idx) begin
      n_fail++;
      $display("FAIL zero_after got done=%b busy=%b en=%b writes=%0d want 0/0/0/0",
               done, busy, mem_wr_en, wr_addr_q.size() - idx);
    end
  endtask

  task automatic test_start_while_busy();
    bit ok, found;
    int idx = wr_addr_q.size();
    mem_ready = 1'b1;
    do_start(10'h080, 8'd1);
    do_start(10'h0C0, 8'd5);
    set_data(4'h2, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0AB);
    send_beat(ok);
    wait_done(found);
    n_checks++;
    if (!ok || !found || wr_addr_q.size() != idx + 1) begin
      n_fail++;
      $display("FAIL busy_start_flow got ok=%b done=%b writes=%0d want 1/1/1",
               ok, found, wr_addr_q.size() - idx);
    end else begin
      n_checks++;
      if (wr_addr_q[idx] !== 10'h080 || wr_data_q[idx] !== 32'h200000AB) begin
        n_fail++;
        $display("FAIL busy_start_write got %h:%h want 080:200000ab", wr_addr_q[idx], wr_data_q[idx]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int idx;
    bit ok0, ok1, ok2;
    mem_ready = 1'b0;
    do_start(10'h200, 8'd4);
    set_data(4'h3, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0AA);
    send_beat(ok0);
    set_data(4'h3, 2'b11, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000);
    send_beat(ok1);
    set_data(4'h3, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0BB);
    send_beat(ok2);
    n_checks++;
    if (!(ok0 && ok1 && ok2) || mem_wr_en !== 1'b1 || mem_wdata !== 32'h300000AA || err !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre got beats=%b%b%b en=%b data=%h err=%b want 111/1/300000aa/1",
               ok0, ok1, ok2, mem_wr_en, mem_wdata, err);
    end
    idx = wr_addr_q.size();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_wr_en, busy, done, err} !== 5'b0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async got flags=%b addr=%h data=%h want 00000/0/0",
               {in_ready, mem_wr_en, busy, done, err}, mem_addr, mem_wdata);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    n_checks++;
    if (checksum !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_checksum got %h want 0", checksum);
    end
`endif
    mem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (wr_addr_q.size() != idx || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_discard got writes=%0d en=%b busy=%b want 0/0/0",
               wr_addr_q.size() - idx, mem_wr_en, busy);
    end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_data_word();
    test_branch_word();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_count_zero();
    test_start_while_busy();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
